sd_slv_dtx: RTL and testbench
=============================

# sd_slv_dtx

SD slave data-line block transmitter. Takes a read-data block byte by byte from the card-side buffer and serializes it onto DAT0. Each block is framed as preamble, start bit, data MSB-first, CRC16 and end bit. It sits directly upstream of the `sd_slv_c16` CRC16 generator: it drives that generator's `clr`/`din`/`cen`/`sft` controls and takes its `q` output as the CRC bit stream.

## Interface
Parameters:
- `BLEN_W`, 12: width of the block-length field, in bytes.
- `PRE`, 2: number of preamble cycles (DAT0 driven high) before the start bit; legal range 1..15.

Ports:
- `clk` in 1: bit clock; one DAT0 bit per cycle.
- `rst` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle request to send a block; sampled only in IDLE.
- `abort` in 1: terminate the current transfer.
- `blk_len` in BLEN_W: block length in bytes; sampled with `start`.
- `rd_req` out 1: the holding register is empty and bytes remain to be fetched.
- `rd_vld` in 1: `rd_data` is valid; a byte transfers when `rd_req & rd_vld`.
- `rd_data` in 8: byte from the buffer.
- `dat_o` out 1: DAT0 output value.
- `dat_oe` out 1: DAT0 output enable.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a transfer ends.
- `err` out 1: one-cycle pulse together with `done` on underrun.
- `crc_clr`, `crc_din`, `crc_cen`, `crc_sft` out 1 each: controls to the CRC16 generator.
- `crc_q` in 1: CRC16 MSB from the generator.

## Operation
- FSM states: IDLE, PRE, START, DATA, CRC, END.
- IDLE:
  - `dat_oe`=0, `dat_o`=1.
  - On `start` with `blk_len`≠0: latch the byte count, go to PRE.
  - `start` with `blk_len`=0 is ignored: no `busy`, no `done`.
- PRE: `PRE` cycles with `dat_oe`=1, `dat_o`=1, then go to START.
- START: one cycle with `dat_o`=0 and `crc_clr`=1. The start bit is not included in the CRC.
- DATA:
  - Shift register `sh` outputs its MSB first; `crc_cen`=1 and `crc_din`=`dat_o`.
  - On entry, and after bit 7 of each byte, `sh` is loaded from the holding register.
  - A 3-bit counter tracks bit position; a BLEN_W counter tracks bytes remaining.
  - After bit 7 of the last byte, go to CRC.
- CRC: 16 cycles with `dat_o`=`crc_q` and `crc_sft`=1, then go to END.
- END: one cycle with `dat_o`=1. Next cycle: IDLE, with `done` pulsed.
- Prefetch:
  - The holding register and its valid flag accept bytes from PRE entry onward.
  - `rd_req` = `busy` & !hold_vld & (bytes fetched < `blk_len`).
  - A byte accepted in the same cycle it is consumed into `sh` counts as available.
- Underrun:
  - Occurs when a load into `sh` is due (START→DATA, or bit 7 with bytes remaining) and no byte is in the holding register.
  - Response: go to IDLE, with `dat_oe`=0 the next cycle and `done`=`err`=1 pulsed.
- `abort`:
  - In any non-IDLE state: next cycle IDLE, `dat_oe`=0, holding register flushed, no `done`.
  - `abort` takes priority over underrun and normal completion.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - State IDLE; `dat_o`=1, `dat_oe`=0.
  - `rd_req`, `busy`, `done`, `err` = 0.
  - All CRC controls = 0; counters and registers = 0.
- `start` sampled at cycle T:
  - `busy`, `dat_oe` and the first preamble bit appear at T+1.
  - Start bit at T+1+PRE.
  - First data bit at T+2+PRE.
- A block of N bytes occupies PRE+1+8N+16+1 cycles with `dat_oe`=1. `done` is asserted the cycle after END, with `dat_oe`=0 and `busy`=0 in that same cycle.
- `rd_req` is registered-state combinational, so the buffer may answer in the same cycle. At most one byte is accepted per cycle.
- CRC controls are mutually exclusive in every cycle. The generator's register updates at the clock edge ending the cycle, so `crc_q` in CRC cycle k is CRC bit 15−k.
- Reset during a transfer: state returns to IDLE at the next edge with all outputs at their reset values.

## Test plan
- `blk_len`=9 with bytes "123456789" (0x31..0x39), `rd_vld` always high, PRE=2:
  - DAT0 sequence 1,1,0, then 72 data bits, then CRC 0x31C3 MSB-first, then 1.
  - `done` at T+93.
  - `err`=0.
- `blk_len`=512 with all bytes 0xFF:
  - CRC field = 0x7FA1.
  - Exactly 512 `rd_req&rd_vld` handshakes.
- Withhold `rd_vld` so the third byte is missing at the end of byte 2:
  - `dat_oe` falls the cycle after bit 7 of byte 2.
  - `done`=`err`=1 for one cycle.
  - No CRC bits are sent.
- Assert `abort` during CRC cycle 5:
  - Next cycle `dat_oe`=0 and `busy`=0.
  - `done` never pulses.
  - A following `start` produces a normal block.
- `start` with `blk_len`=0, and `start` pulsed while `busy`:
  - Both are ignored; there is no extra `done` and the in-flight stream is unchanged.
- Drive `rst`=0 mid-DATA:
  - All outputs take their reset values at the next edge.
  - `rd_req`=0 until the next `start`.

Source files
------------

// File: rtl/sd_slv_dtx_if.sv
// sd_slv_dtx_if: bundle of the block-transmitter control, buffer-read, DAT0
// and CRC16-generator signals.
//   slave  - the transmitter side (sd_slv_dtx)
//   master - the controller / buffer / CRC side driving it
interface sd_slv_dtx_if #(
    parameter int BLEN_W = 12
);
    logic              start;
    logic              abort;
    logic [BLEN_W-1:0] blk_len;
    logic              rd_req;
    logic              rd_vld;
    logic [7:0]        rd_data;
    logic              dat_o;
    logic              dat_oe;
    logic              busy;
    logic              done;
    logic              err;
    logic              crc_clr;
    logic              crc_din;
    logic              crc_cen;
    logic              crc_sft;
    logic              crc_q;

    modport slave (
        input  start, abort, blk_len, rd_vld, rd_data, crc_q,
        output rd_req, dat_o, dat_oe, busy, done, err,
               crc_clr, crc_din, crc_cen, crc_sft
    );

    modport master (
        output start, abort, blk_len, rd_vld, rd_data, crc_q,
        input  rd_req, dat_o, dat_oe, busy, done, err,
               crc_clr, crc_din, crc_cen, crc_sft
    );
endinterface

// File: rtl/sd_slv_dtx.sv
// sd_slv_dtx: SD slave DAT0 read-block transmitter.
// Frames a block as preamble (high), start bit (0), data bytes MSB-first,
// 16 CRC bits taken from the external CRC16 generator, and an end bit (1).
// Ports:
//   clk          bit clock, one DAT0 bit per cycle
//   rst          synchronous active-low reset
//   bus.start    request to send blk_len bytes (taken only in IDLE)
//   bus.abort    kill the current transfer, no done
//   bus.rd_*     byte fetch handshake from the card buffer (one-byte prefetch)
//   bus.dat_o/oe DAT0 value and enable
//   bus.busy     not IDLE; bus.done/err end-of-transfer pulses
//   bus.crc_*    controls to / MSB from the CRC16 generator
module sd_slv_dtx #(
    parameter int BLEN_W = 12,
    parameter int PRE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    sd_slv_dtx_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_START, ST_DATA, ST_CRC, ST_END
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        pre_cnt;
    logic [3:0]        crc_cnt;
    logic [2:0]        bit_cnt;
    logic [BLEN_W-1:0] len;        // latched block length
    logic [BLEN_W-1:0] fetch_cnt;  // bytes accepted from the buffer
    logic [BLEN_W-1:0] byte_rem;   // bytes not yet loaded into sh
    logic [7:0]        sh;
    logic [7:0]        hold;
    logic              hold_vld;
    logic              done_q;
    logic              err_q;

    logic       busy;
    logic       rd_req;
    logic       acc;
    logic       avail;
    logic       load_due;
    logic       load;
    logic       underrun;
    logic       kill;
    logic [7:0] load_byte;

    // Fetch / load decisions. A byte arriving in the same cycle a load is due
    // bypasses the holding register straight into sh.
    always_comb begin
        busy      = (state != ST_IDLE);
        rd_req    = busy && !hold_vld && (fetch_cnt < len);
        acc       = rd_req && bus.rd_vld;
        avail     = hold_vld || acc;
        load_byte = hold_vld ? hold : bus.rd_data;
        load_due  = (state == ST_START) ||
                    ((state == ST_DATA) && (bit_cnt == 3'd7) && (byte_rem != '0));
        kill      = busy && bus.abort;
        load      = load_due && avail && !kill;
        underrun  = load_due && !avail && !kill;
    end

    always_comb begin
        state_nx    = state;
        bus.dat_o   = 1'b1;
        bus.crc_clr = 1'b0;
        bus.crc_din = 1'b0;
        bus.crc_cen = 1'b0;
        bus.crc_sft = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.blk_len != '0)) state_nx = ST_PRE;
            end
            ST_PRE: begin
                if (pre_cnt == 4'(PRE - 1)) state_nx = ST_START;
            end
            ST_START: begin
                bus.dat_o   = 1'b0;
                bus.crc_clr = 1'b1;
                state_nx    = ST_DATA;
            end
            ST_DATA: begin
                bus.dat_o   = sh[7];
                bus.crc_din = sh[7];
                bus.crc_cen = 1'b1;
                if ((bit_cnt == 3'd7) && (byte_rem == '0)) state_nx = ST_CRC;
            end
            ST_CRC: begin
                bus.dat_o   = bus.crc_q;
                bus.crc_sft = 1'b1;
                if (crc_cnt == 4'd15) state_nx = ST_END;
            end
            ST_END: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // abort outranks underrun, which outranks normal sequencing
        if (underrun || kill) state_nx = ST_IDLE;
    end

    always_comb begin
        bus.busy   = busy;
        bus.dat_oe = busy;
        bus.rd_req = rd_req;
        bus.done   = done_q;
        bus.err    = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            crc_cnt   <= '0;
            bit_cnt   <= '0;
            len       <= '0;
            fetch_cnt <= '0;
            byte_rem  <= '0;
            sh        <= '0;
            hold      <= '0;
            hold_vld  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= underrun || ((state == ST_END) && !kill);
            err_q  <= underrun;

            if (acc) fetch_cnt <= fetch_cnt + 1'b1;

            if (load) begin
                sh       <= load_byte;
                byte_rem <= byte_rem - 1'b1;
            end else if (state == ST_DATA) begin
                sh <= {sh[6:0], 1'b0};
            end

            if (load) begin
                hold_vld <= 1'b0;
            end else if (acc) begin
                hold     <= bus.rd_data;
                hold_vld <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start && (bus.blk_len != '0)) begin
                        len       <= bus.blk_len;
                        byte_rem  <= bus.blk_len;
                        fetch_cnt <= '0;
                        pre_cnt   <= '0;
                    end
                end
                ST_PRE:   pre_cnt <= pre_cnt + 1'b1;
                ST_START: bit_cnt <= '0;
                ST_DATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    crc_cnt <= '0;
                end
                ST_CRC:   crc_cnt <= crc_cnt + 1'b1;
                default: ;
            endcase

            // leaving a transfer for any reason flushes the prefetch
            if (busy && (state_nx == ST_IDLE)) hold_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sd_slv_dtx.sv
module tb_sd_slv_dtx;
    localparam int BLEN_W = 12;
    localparam int PRE    = 2;
    localparam int VMAX   = 4200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sd_slv_dtx_if #(.BLEN_W(BLEN_W)) bus ();

    sd_slv_dtx #(.BLEN_W(BLEN_W), .PRE(PRE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Card buffer: presents src_mem[idx], idx counts completed handshakes.
    logic [7:0] src_mem [0:1023];
    int         idx = 0;
    logic       idx_clr = 1'b0;
    bit         vld_pat [0:VMAX-1];

    always @(posedge clk) begin
        if (idx_clr) idx <= 0;
        else if (bus.rd_req && bus.rd_vld) idx <= idx + 1;
    end
    assign bus.rd_data = src_mem[idx];

    // Stand-in for the downstream CRC16 generator (x^16+x^12+x^5+1, init 0).
    logic [15:0] crc_r = 16'h0;
    always @(posedge clk) begin
        if (bus.crc_clr)      crc_r <= 16'h0;
        else if (bus.crc_cen) crc_r <= {crc_r[14:0], 1'b0} ^ ((bus.crc_din ^ crc_r[15]) ? 16'h1021 : 16'h0);
        else if (bus.crc_sft) crc_r <= {crc_r[14:0], 1'b0};
    end
    assign bus.crc_q = crc_r[15];

    // Reference CRC over the first n source bytes, byte-oriented form.
    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c;
        c = 16'h0;
        for (int i = 0; i < n; i++) begin
            c = c ^ {src_mem[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic gen_vld(input int pct);
        for (int i = 0; i < VMAX; i++) vld_pat[i] = ($urandom_range(0, 99) < pct);
    endtask

    // Sends one block and checks every cycle against the framing rules.
    // abort_c / busy_c: cycle (relative to the start cycle 0) at which to
    // pulse abort / a stray start, or -1.
    task automatic run_block(input int n, input int abort_c, input int busy_c,
                             input bit chk_k, input logic [15:0] crc_k);
        int          ku, earliest, lk, e_last, done_c, c_crc0, d, exp_hs;
        bit          found, err_exp;
        logic [15:0] crc_ref, rx_crc;
        logic [7:0]  bt;
        logic        eb;

        crc_ref  = crc16(n);
        ku       = -1;
        earliest = 1;
        for (int k = 0; k < n; k++) begin
            lk    = PRE + 1 + 8 * k;
            found = 0;
            for (int c = earliest; c <= lk; c++) if (vld_pat[c]) found = 1;
            if (!found) begin
                ku = k;
                break;
            end
            earliest = lk + 1;
        end
        c_crc0 = PRE + 2 + 8 * n;
        if (abort_c >= 0)  e_last = abort_c;
        else if (ku >= 0)  e_last = PRE + 1 + 8 * ku;
        else               e_last = PRE + 1 + 8 * n + 16 + 1;
        done_c  = (abort_c < 0) ? e_last + 1 : -1;
        err_exp = (ku >= 0) && (abort_c < 0);
        exp_hs  = (ku >= 0) ? ku : n;
        rx_crc  = 16'h0;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.blk_len = BLEN_W'(n);
        bus.rd_vld  = 1'b0;
        idx_clr     = 1'b1;
        for (int c = 1; c <= e_last + 3; c++) begin
            @(negedge clk);
            idx_clr     = 1'b0;
            bus.start   = (c == busy_c);
            if (c == busy_c) bus.blk_len = BLEN_W'(7);
            bus.abort   = (c == abort_c);
            bus.rd_vld  = vld_pat[c];
            if (c <= e_last) begin
                if (c <= PRE)           eb = 1'b1;
                else if (c == PRE + 1)  eb = 1'b0;
                else if (c < c_crc0) begin
                    d  = c - PRE - 2;
                    bt = src_mem[d / 8];
                    eb = bt[7 - (d % 8)];
                end
                else if (c < c_crc0 + 16) eb = crc_ref[15 - (c - c_crc0)];
                else                      eb = 1'b1;
                chk("dat", {bus.dat_oe, bus.dat_o, bus.busy}, {1'b1, eb, 1'b1});
                if (c >= c_crc0 && c < c_crc0 + 16) rx_crc = {rx_crc[14:0], bus.dat_o};
            end else begin
                chk("idle_oe", {bus.dat_oe, bus.busy}, 2'b00);
            end
            chk("done_err", {bus.done, bus.err}, ((c == done_c) ? {1'b1, err_exp} : 2'b00));
            chk("crc_excl", ($countones({bus.crc_clr, bus.crc_cen, bus.crc_sft}) <= 1), 1'b1);
        end
        bus.abort  = 1'b0;
        bus.rd_vld = 1'b0;
        chk("handshakes", idx, exp_hs);
        if (ku < 0 && abort_c < 0) begin
            chk("crc_field", rx_crc, crc_ref);
            if (chk_k) chk("crc_const", rx_crc, crc_k);
        end
    endtask

    initial begin
        int n;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.blk_len = '0;
        bus.rd_vld  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out", {bus.dat_oe, bus.dat_o, bus.busy, bus.done, bus.err, bus.rd_req}, 6'b010000);
        chk("rst_crc", {bus.crc_clr, bus.crc_din, bus.crc_cen, bus.crc_sft}, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst", {bus.dat_oe, bus.dat_o, bus.busy, bus.done, bus.rd_req}, 5'b01000);

        for (int i = 0; i < 9; i++) src_mem[i] = 8'h31 + 8'(i);
        gen_vld(100);
        run_block(9, -1, -1, 1'b1, 16'h31C3);

        for (int i = 0; i < 512; i++) src_mem[i] = 8'hFF;
        run_block(512, -1, -1, 1'b1, 16'h7FA1);

        for (int i = 0; i < 6; i++) src_mem[i] = 8'($urandom);
        gen_vld(100);
        for (int c = PRE + 10; c <= PRE + 17; c++) vld_pat[c] = 1'b0;
        run_block(6, -1, -1, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++) src_mem[i] = 8'($urandom);
        gen_vld(100);
        run_block(4, PRE + 2 + 32 + 5, -1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) src_mem[i] = 8'($urandom);
        run_block(3, -1, -1, 1'b0, 16'h0);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.blk_len = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("zero_len", {bus.busy, bus.dat_oe, bus.done, bus.rd_req}, 4'b0000);
        end

        for (int i = 0; i < 5; i++) src_mem[i] = 8'($urandom);
        gen_vld(80);
        run_block(5, -1, PRE + 10, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++) src_mem[i] = 8'($urandom);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.blk_len = BLEN_W'(4);
        bus.rd_vld  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (PRE + 8) @(negedge clk);
        chk("mid_busy", bus.busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out", {bus.dat_oe, bus.dat_o, bus.busy, bus.done, bus.err, bus.rd_req}, 6'b010000);
        chk("rst_mid_crc", {bus.crc_clr, bus.crc_din, bus.crc_cen, bus.crc_sft}, 4'b0000);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_rdreq", {bus.rd_req, bus.busy, bus.done}, 3'b000);
        end
        bus.rd_vld = 1'b0;

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) src_mem[i] = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       gen_vld(100);
                1:       gen_vld(90);
                default: gen_vld(50);
            endcase
            run_block(n, -1, -1, 1'b0, 16'h0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
